// File: rtl/mem_access_ctrl.sv
// Fetch + load/store initiator for a word-addressed synchronous memory; data port wins arbitration.
// Big-endian lane extract/extend on loads; byte/half stores become read-modify-write sequences.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_data,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic        mem_wr_en,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      state;
    logic [2:0]  cnt;
    logic        op_fetch;
    logic        op_we;
    logic        op_uns;
    logic [1:0]  op_size;
    logic [1:0]  op_off;
    logic [15:0] op_wdata;
    logic        d_mis;
    logic        if_mis;

    always_comb begin
        d_mis = 1'b0;
        case (d_size)
            2'b00:   d_mis = 1'b0;
            2'b01:   d_mis = d_addr[0];
            default: d_mis = |d_addr[1:0];
        endcase
    end

    assign if_mis = |if_addr[1:0];
    assign busy   = (state != IDLE);

    // Offset 0 is the most significant lane of the word.
    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   lane_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   lane_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: lane_extract = w;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [15:0] wd,
                                               input logic [1:0] size, input logic [1:0] off);
        lane_merge = w;
        if (size == 2'b01) begin
            if (off[1]) lane_merge[15:0]  = wd;
            else        lane_merge[31:16] = wd;
        end else begin
            case (off)
                2'd0:    lane_merge[31:24] = wd[7:0];
                2'd1:    lane_merge[23:16] = wd[7:0];
                2'd2:    lane_merge[15:8]  = wd[7:0];
                default: lane_merge[7:0]   = wd[7:0];
            endcase
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_fetch    <= 1'b0;
            op_we       <= 1'b0;
            op_uns      <= 1'b0;
            op_size     <= '0;
            op_off      <= '0;
            op_wdata    <= '0;
            if_ready    <= 1'b0;
            if_valid    <= 1'b0;
            if_data     <= '0;
            if_err      <= 1'b0;
            d_ready     <= 1'b0;
            d_valid     <= 1'b0;
            d_rdata     <= '0;
            d_err       <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_wr_en   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (d_req) begin
                        d_ready  <= 1'b1;
                        op_fetch <= 1'b0;
                        op_we    <= d_we;
                        op_uns   <= d_unsigned;
                        op_size  <= d_size;
                        op_off   <= d_addr[1:0];
                        op_wdata <= d_wdata[15:0];
                        mem_addr <= d_addr[31:2];
                        if (d_mis) begin
                            d_valid <= 1'b1;
                            d_err   <= 1'b1;
                            state   <= RESP;
                        end else if (d_we && !d_size[1]) begin
                            state <= RMW_RD;
                        end else begin
                            state <= RD_WAIT;
                            if (d_we) begin
                                mem_wr_en   <= 1'b1;
                                mem_data_in <= d_wdata;
                            end
                        end
                    end else if (if_req) begin
                        if_ready <= 1'b1;
                        op_fetch <= 1'b1;
                        op_we    <= 1'b0;
                        op_uns   <= 1'b0;
                        op_size  <= 2'b10;
                        op_off   <= if_addr[1:0];
                        mem_addr <= if_addr[31:2];
                        if (if_mis) begin
                            if_valid <= 1'b1;
                            if_err   <= 1'b1;
                            state    <= RESP;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (op_we) begin
                        // Word store: the single write cycle has just completed.
                        mem_wr_en   <= 1'b0;
                        mem_data_in <= '0;
                        d_valid     <= 1'b1;
                        state       <= RESP;
                    end else if (cnt == LAT) begin
                        if (op_fetch) begin
                            if_valid <= 1'b1;
                            if_data  <= mem_data_out;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= lane_extract(mem_data_out, op_size, op_off, op_uns);
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RMW_RD: begin
                    if (cnt == LAT) begin
                        mem_wr_en   <= 1'b1;
                        mem_data_in <= lane_merge(mem_data_out, op_wdata, op_size, op_off);
                        state       <= RMW_WR;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RMW_WR: begin
                    mem_wr_en   <= 1'b0;
                    mem_data_in <= '0;
                    d_valid     <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if_valid <= 1'b0;
                    if_err   <= 1'b0;
                    if_data  <= '0;
                    d_valid  <= 1'b0;
                    d_err    <= 1'b0;
                    d_rdata  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: byte-array reference model, scoreboard queues checked by a negedge monitor.
module tb_mem_access_ctrl;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready, if_valid, if_err;
    logic [31:0] if_data;
    logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ready, d_valid, d_err;
    logic [31:0] d_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_in, mem_data_out;
    logic        mem_wr_en, busy;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
        .if_data(if_data), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_wr_en(mem_wr_en),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    // Synchronous memory with LAT-cycle read pipeline and a backdoor write port.
    logic [31:0] mem [16];
    logic [31:0] pipe [LAT];
    logic        bd_en = 1'b0;
    logic [3:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;
    always @(posedge clk) begin
        if (bd_en) mem[bd_idx] <= bd_val;
        else if (mem_wr_en) mem[mem_addr[3:0]] <= mem_data_in;
        pipe[0] <= mem[mem_addr[3:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_out = pipe[LAT-1];

    typedef struct { logic [31:0] data; logic err; int lat; logic [29:0] waddr; } exp_t;
    typedef struct { logic [29:0] a; logic [31:0] d; } wr_t;

    exp_t        qd[$], qf[$];
    wr_t         qw[$];
    logic [7:0]  rb [64];
    int          total = 0, bad = 0, cyc = 0, d_acc = 0, f_acc = 0;
    exp_t        me;
    wr_t         mw;
    logic [31:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rword(input int i);
        return {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]};
    endfunction

    function automatic logic outs_any();
        return |{if_ready, if_valid, if_data, if_err, d_ready, d_valid, d_rdata, d_err,
                 mem_addr, mem_data_in, mem_wr_en, busy};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (d_ready) begin
                d_acc = cyc;
                if (qd.size() > 0 && !qd[0].err) chk("d_mem_addr", mem_addr, qd[0].waddr);
            end
            if (if_ready) begin
                f_acc = cyc;
                if (qf.size() > 0 && !qf[0].err) chk("if_mem_addr", mem_addr, qf[0].waddr);
            end
            if (mem_wr_en) begin
                if (qw.size() > 0) begin
                    mw = qw.pop_front();
                    chk("wr_addr", mem_addr, mw.a);
                    chk("wr_data", mem_data_in, mw.d);
                end else chk("wr_unexpected", mem_wr_en, 0);
            end
            if (d_valid) begin
                if (qd.size() > 0) begin
                    me = qd.pop_front();
                    chk("d_rdata", d_rdata, me.data);
                    chk("d_err", d_err, me.err);
                    chk("d_latency", cyc - d_acc, me.lat);
                end else chk("d_valid_unexpected", d_valid, 0);
            end
            if (if_valid) begin
                if (qf.size() > 0) begin
                    me = qf.pop_front();
                    chk("if_data", if_data, me.data);
                    chk("if_err", if_err, me.err);
                    chk("if_latency", cyc - f_acc, me.lat);
                end else chk("if_valid_unexpected", if_valid, 0);
            end
        end
    end

    task automatic set_word(input int i, input logic [31:0] v);
        bd_idx = 4'(i); bd_val = v; bd_en = 1'b1;
        @(negedge clk);
        bd_en = 1'b0;
        for (int k = 0; k < 4; k++) rb[4*i+k] = v[8*(3-k) +: 8];
    endtask

    task automatic prep_data(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
        exp_t e; wr_t w; int nb, ai; logic [31:0] v;
        nb = sz[1] ? 4 : (sz[0] ? 2 : 1);
        ai = int'(a[5:0]);
        e.err = (ai % nb) != 0;
        e.data = '0; e.waddr = a[31:2]; e.lat = 0;
        v = '0;
        if (!e.err && we) begin
            for (int k = 0; k < nb; k++) rb[ai+k] = wd[8*(nb-1-k) +: 8];
            w.a = a[31:2]; w.d = rword(ai / 4);
            qw.push_back(w);
            e.lat = (nb == 4) ? 1 : LAT + 2;
        end else if (!e.err) begin
            for (int k = 0; k < nb; k++) v = {v[23:0], rb[ai+k]};
            if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8*nb));
            e.data = v; e.lat = LAT + 1;
        end
        qd.push_back(e);
    endtask

    task automatic prep_fetch(input logic [31:0] a);
        exp_t e;
        e.err = a[1:0] != 2'b00;
        e.data = e.err ? 32'h0 : rword(int'(a[5:2]));
        e.lat = e.err ? 0 : LAT + 1;
        e.waddr = a[31:2];
        qf.push_back(e);
    endtask

    task automatic finish_op(input bit is_d, output logic [31:0] res);
        bit done;
        done = 1'b0; res = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (is_d && d_ready) d_req = 1'b0;
            if (!is_d && if_ready) if_req = 1'b0;
            if (is_d ? d_valid : if_valid) begin
                done = 1'b1;
                res = is_d ? d_rdata : if_data;
            end
        end
        chk("op_completes", done, 1);
        d_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, output logic [31:0] res);
        prep_data(we, sz, uns, a, wd);
        d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd; d_req = 1'b1;
        finish_op(1'b1, res);
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] res);
        prep_fetch(a);
        if_addr = a; if_req = 1'b1;
        finish_op(1'b0, res);
    endtask

    // Reset during an in-flight op: no response, outputs cleared, no memory write.
    task automatic reset_mid(input bit rmw);
        bit hit;
        int idx;
        idx = rmw ? 8 : 4;
        d_we = rmw; d_size = rmw ? 2'b00 : 2'b10; d_unsigned = 1'b0;
        d_addr = rmw ? 32'h21 : 32'h10; d_wdata = $urandom; d_req = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #1;
            if (d_ready) d_req = 1'b0;
            else if (rmw ? mem_wr_en : busy) hit = 1'b1;
        end
        chk(rmw ? "rst_reached_rmw_wr" : "rst_reached_rd_wait", hit, 1);
        rst = 1'b0; d_req = 1'b0;
        #1;
        chk(rmw ? "rst_outs_rmw" : "rst_outs_rd", outs_any(), 0);
        @(negedge clk); @(negedge clk);
        chk(rmw ? "rst_mem_rmw" : "rst_mem_rd", mem[idx], rword(idx));
        rst = 1'b1;
    endtask

    initial begin
        int cd_r, cf_r, cd_v;
        bit fdone;
        logic [31:0] a;
        #1 rst = 1'b0;
        #1 chk("reset_outs", outs_any(), 0);
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        set_word(1, 32'h20020005);
        set_word(3, 32'h00430820);
        rst = 1'b1;

        do_fetch(32'h4, got);
        chk("t2_if_data", got, 32'h20020005);

        do_data(1'b1, 2'b00, 1'b0, 32'hD, 32'h000000AB, got);
        chk("t3_mem3", mem[3], 32'h00AB0820);
        do_data(1'b0, 2'b00, 1'b0, 32'hD, 32'h0, got);
        chk("t4_signed_byte", got, 32'hFFFFFFAB);
        do_data(1'b0, 2'b00, 1'b1, 32'hD, 32'h0, got);
        chk("t4_unsigned_byte", got, 32'h000000AB);
        do_data(1'b0, 2'b01, 1'b0, 32'hE, 32'h0, got);
        chk("t4_half", got, 32'h00000820);

        // Simultaneous requests: data first, fetch accepted right after the data response.
        prep_data(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        prep_fetch(32'hC);
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h4; d_req = 1'b1;
        if_addr = 32'hC; if_req = 1'b1;
        cd_r = -100; cf_r = -100; cd_v = -100; fdone = 1'b0;
        for (int i = 0; i < 40 && !fdone; i++) begin
            @(negedge clk);
            if (d_ready) begin
                cd_r = cyc; d_req = 1'b0;
                chk("t5_if_ready_low", if_ready, 0);
            end
            if (if_ready) begin cf_r = cyc; if_req = 1'b0; end
            if (d_valid) cd_v = cyc;
            if (if_valid) fdone = 1'b1;
        end
        chk("t5_fetch_done", fdone, 1);
        chk("t5_d_first", cf_r > cd_r, 1);
        chk("t5_fetch_after_valid", cf_r - cd_v, 2);
        d_req = 1'b0; if_req = 1'b0;

        do_data(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, got);
        chk("t6_load_rdata", got, 32'h0);
        do_data(1'b1, 2'b01, 1'b0, 32'h3, 32'h1234, got);
        do_fetch(32'h2, got);

        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int n = 0; n < 250; n++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) do_fetch(a, got);
            else do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), a, $urandom, got);
        end

        @(negedge clk);
        chk("queues_drained", qd.size() + qf.size() + qw.size(), 0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], rword(i));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
